uimm_fetch_issue: RTL

Front-end feeder for the U-type execute units (LUI / AUIPC).
- Fetches 32-bit instruction words from an instruction-memory port.
- Decodes the U-type opcodes and issues registered `pc`/`imm`/enable values over a valid/ready handshake.
- Sits between the instruction memory and the LUI/AUIPC units, producing exactly the `en`, `pc` and `imm` those units consume.
- Drives `pc` as fetch address + 4, because AUIPC computes `pc - 4 + imm`.

---
 rtl/uimm_pkg.sv | 19 +
 rtl/uimm_decode.sv | 16 +
 rtl/uimm_fetch_issue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uimm_pkg.sv
// Shared definitions for the U-type fetch/issue front end: opcodes, FSM
// states and the U-immediate builder.
package uimm_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        DRAIN
    } state_e;

    // Upper 20 bits placed at [31:12], sign-extended to 64 bits.
    function automatic logic [63:0] u_imm(input logic [31:0] inst);
        return {{32{inst[31]}}, inst[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/uimm_decode.sv
// Combinational U-type decoder (LUI / AUIPC detect plus immediate); shared
// with the later decode stage.
module uimm_decode
    import uimm_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_lui,
    output logic        is_auipc,
    output logic [63:0] imm
);

    assign is_lui   = (inst[6:0] == OPC_LUI);
    assign is_auipc = (inst[6:0] == OPC_AUIPC);
    assign imm      = u_imm(inst);

endmodule

// File: rtl/uimm_fetch_issue.sv
// Fetches instruction words and issues registered LUI/AUIPC operands over a
// valid/ready handshake. Define UIMM_FETCH_ISSUE_DEBUG_EN for debug ports.
module uimm_fetch_issue
    import uimm_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic        lui_en,
    output logic        auipc_en,
    output logic [63:0] pc_out,
    output logic [63:0] imm_out,
    output logic        skip_pulse
`ifdef UIMM_FETCH_ISSUE_DEBUG_EN
    ,
    output logic        debug_inst_analy,
    output logic [31:0] debug_issue_cnt
`endif
);

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] redir_pc_q, redir_pc_d;
    logic        req_q, req_d;
    logic [63:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        lui_q, lui_d;
    logic        auipc_q, auipc_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic [63:0] imm_q, imm_d;
    logic        skip_q, skip_d;
    logic        handshake;

    logic        dec_lui, dec_auipc;
    logic [63:0] dec_imm;
    logic [63:0] pc_plus4;
    logic [63:0] drain_tgt;

    uimm_decode u_dec (
        .inst     (imem_rdata),
        .is_lui   (dec_lui),
        .is_auipc (dec_auipc),
        .imm      (dec_imm)
    );

    assign pc_plus4  = fetch_pc_q + 64'd4;
    assign drain_tgt = redirect_valid ? redirect_pc : redir_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        lui_d      = lui_q;
        auipc_d    = auipc_q;
        pc_out_d   = pc_out_q;
        imm_d      = imm_q;
        skip_d     = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    // No transfer outstanding, so a redirect just retargets.
                    req_d      = 1'b1;
                    fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q;
                    addr_d     = redirect_valid ? redirect_pc : fetch_pc_q;
                end else if (imem_ack) begin
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                        addr_d     = redirect_pc;
                    end else if (dec_lui || dec_auipc) begin
                        valid_d    = 1'b1;
                        lui_d      = dec_lui;
                        auipc_d    = dec_auipc;
                        pc_out_d   = pc_plus4;
                        imm_d      = dec_imm;
                        fetch_pc_d = pc_plus4;
                        req_d      = 1'b0;
                        state_d    = ISSUE;
                    end else begin
                        skip_d     = 1'b1;
                        fetch_pc_d = pc_plus4;
                        addr_d     = pc_plus4;
                    end
                end else if (redirect_valid) begin
                    // The bus transfer cannot be withdrawn; wait it out.
                    redir_pc_d = redirect_pc;
                    state_d    = DRAIN;
                end
            end
            ISSUE: begin
                if (issue_ready || redirect_valid) begin
                    handshake  = issue_ready;
                    valid_d    = 1'b0;
                    lui_d      = 1'b0;
                    auipc_d    = 1'b0;
                    pc_out_d   = '0;
                    imm_d      = '0;
                    req_d      = 1'b1;
                    fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q;
                    addr_d     = redirect_valid ? redirect_pc : fetch_pc_q;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    fetch_pc_d = drain_tgt;
                    addr_d     = drain_tgt;
                    state_d    = FETCH;
                end else if (redirect_valid) begin
                    redir_pc_d = redirect_pc;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            lui_q      <= 1'b0;
            auipc_q    <= 1'b0;
            pc_out_q   <= '0;
            imm_q      <= '0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            lui_q      <= lui_d;
            auipc_q    <= auipc_d;
            pc_out_q   <= pc_out_d;
            imm_q      <= imm_d;
            skip_q     <= skip_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign issue_valid = valid_q;
    assign lui_en      = lui_q;
    assign auipc_en    = auipc_q;
    assign pc_out      = pc_out_q;
    assign imm_out     = imm_q;
    assign skip_pulse  = skip_q;

`ifdef UIMM_FETCH_ISSUE_DEBUG_EN
    logic [31:0] dbg_cnt_q, dbg_cnt_d;

    always_comb begin
        dbg_cnt_d = dbg_cnt_q + {31'd0, handshake};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_cnt_q <= '0;
        else        dbg_cnt_q <= dbg_cnt_d;
    end

    assign debug_inst_analy = valid_q;
    assign debug_issue_cnt  = dbg_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = handshake;
`endif

endmodule
